// File: rtl/dff_delay_line.sv
// dff_delay_line: stallable fixed-latency delay line of DEPTH stages.
// Ports: clk, rst (async, active-low), en (advance), clr (sync clear),
//   d/d_valid (stage 0 input), q/q_valid (last stage), occupancy
//   (valid stage count), full, empty.
module dff_delay_line #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic [WIDTH-1:0]             d,
  input  logic                         d_valid,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         full,
  output logic                         empty
);

  localparam int OW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [OW-1:0]    r_occ;
  logic [OW:0]      w_occ_nxt;

  // One extra bit so the add/subtract never wraps mid-expression.
  assign w_occ_nxt = {1'b0, r_occ}
                   + {{OW{1'b0}}, d_valid}
                   - {{OW{1'b0}}, r_vld[DEPTH-1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= RESET_VAL;
      end
      r_vld <= '0;
      r_occ <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= RESET_VAL;
      end
      r_vld <= '0;
      r_occ <= '0;
    end else if (en) begin
      r_data[0] <= d;
      r_vld[0]  <= d_valid;
      // Data shifts regardless of valid.
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i] <= r_data[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
      r_occ <= w_occ_nxt[OW-1:0];
    end
  end

  assign q         = r_data[DEPTH-1];
  assign q_valid   = r_vld[DEPTH-1];
  assign occupancy = r_occ;
  assign full      = (r_occ == OW'(DEPTH));
  assign empty     = (r_occ == '0);

endmodule

// File: tb/tb_dff_delay_line.sv
// tb_dff_delay_line: random + directed bench for dff_delay_line.
// Two instances: DEPTH=4/RESET_VAL=00 and DEPTH=1/RESET_VAL=A5.
module tb_dff_delay_line;

  typedef struct {
    logic [7:0] d;
    logic       v;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] d = 8'h00;
  logic       d_valid = 1'b0;

  logic [7:0] q4;
  logic       qv4;
  logic [2:0] occ4;
  logic       full4;
  logic       empty4;
  logic [7:0] q1;
  logic       qv1;
  logic [0:0] occ1;
  logic       full1;
  logic       empty1;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  ent_t h4[$];
  ent_t h1[$];

  always #5 clk = ~clk;

  dff_delay_line #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u4 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .d(d), .d_valid(d_valid),
    .q(q4), .q_valid(qv4), .occupancy(occ4),
    .full(full4), .empty(empty4)
  );

  dff_delay_line #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'hA5)) u1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .d(d), .d_valid(d_valid),
    .q(q1), .q_valid(qv1), .occupancy(occ1),
    .full(full1), .empty(empty1)
  );

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", n, a, e);
    end
  endtask

  // Model: a window of the last DEPTH enabled samples; q is the oldest.
  task automatic mreset();
    h4.delete();
    for (int i = 0; i < 4; i++) h4.push_back('{8'h00, 1'b0});
    h1.delete();
    h1.push_back('{8'hA5, 1'b0});
  endtask

  function automatic int vcount(ent_t h[$]);
    int c = 0;
    foreach (h[i]) c += int'(h[i].v);
    return c;
  endfunction

  initial mreset();

  always @(posedge clk or negedge rst) begin
    if (!rst || clr) begin
      mreset();
    end else if (en) begin
      h4.push_back('{d, d_valid});
      void'(h4.pop_front());
      h1.push_back('{d, d_valid});
      void'(h1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int o4;
      int o1;
      o4 = vcount(h4);
      o1 = vcount(h1);
      chk("m_q4", 32'(q4), 32'(h4[0].d));
      chk("m_qv4", 32'(qv4), 32'(h4[0].v));
      chk("m_occ4", 32'(occ4), 32'(o4));
      chk("m_full4", 32'(full4), 32'(o4 == 4));
      chk("m_empty4", 32'(empty4), 32'(o4 == 0));
      chk("m_q1", 32'(q1), 32'(h1[0].d));
      chk("m_qv1", 32'(qv1), 32'(h1[0].v));
      chk("m_occ1", 32'(occ1), 32'(o1));
      chk("m_full1", 32'(full1), 32'(o1 == 1));
      chk("m_empty1", 32'(empty1), 32'(o1 == 0));
    end
  end

  task automatic cyc(logic e, logic c, logic [7:0] dd, logic dv);
    en = e;
    clr = c;
    d = dd;
    d_valid = dv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pk;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q4", 32'(q4), 32'h00);
    chk("rst_empty4", 32'(empty4), 32'h1);
    chk("rst_q1", 32'(q1), 32'hA5);
    rst = 1'b1;
    chk_on = 1'b1;

    // Fill and stream.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 8'(8'h11 * (k + 1)), 1'b1);
      chk("fill_occ", 32'(occ4), 32'(k + 1));
    end
    chk("fill_q", 32'(q4), 32'h11);
    chk("fill_qv", 32'(qv4), 32'h1);
    chk("fill_full", 32'(full4), 32'h1);
    cyc(1'b1, 1'b0, 8'h55, 1'b1);
    chk("stream_q", 32'(q4), 32'h22);

    // Stall while full.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 8'($urandom), 1'($urandom));
      chk("stall_q", 32'(q4), 32'h22);
      chk("stall_occ", 32'(occ4), 32'h4);
    end
    cyc(1'b1, 1'b0, 8'h66, 1'b1);
    chk("resume_q", 32'(q4), 32'h33);

    // Clear overrides en; d not captured.
    cyc(1'b1, 1'b1, 8'h77, 1'b1);
    chk("clr_q", 32'(q4), 32'h00);
    chk("clr_qv", 32'(qv4), 32'h0);
    chk("clr_occ", 32'(occ4), 32'h0);

    // Valid pattern 1,0,1.
    pk = 0;
    cyc(1'b1, 1'b0, 8'hAA, 1'b1);
    if (int'(occ4) > pk) pk = int'(occ4);
    cyc(1'b1, 1'b0, 8'hBB, 1'b0);
    if (int'(occ4) > pk) pk = int'(occ4);
    cyc(1'b1, 1'b0, 8'hCC, 1'b1);
    if (int'(occ4) > pk) pk = int'(occ4);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    if (int'(occ4) > pk) pk = int'(occ4);
    chk("pat_q4", 32'(q4), 32'hAA);
    chk("pat_qv4", 32'(qv4), 32'h1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    if (int'(occ4) > pk) pk = int'(occ4);
    chk("pat_qv5", 32'(qv4), 32'h0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    if (int'(occ4) > pk) pk = int'(occ4);
    chk("pat_qv6", 32'(qv4), 32'h1);
    chk("pat_q6", 32'(q4), 32'hCC);
    chk("pat_peak", 32'(pk), 32'h2);

    // Depth-1 follows d, holds on stall.
    cyc(1'b1, 1'b0, 8'h3C, 1'b1);
    chk("d1_q", 32'(q1), 32'h3C);
    cyc(1'b0, 1'b0, 8'h99, 1'b0);
    chk("d1_hold", 32'(q1), 32'h3C);

    // Async reset mid-cycle.
    cyc(1'b1, 1'b0, 8'h5A, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_q4", 32'(q4), 32'h00);
    chk("arst_qv4", 32'(qv4), 32'h0);
    chk("arst_occ4", 32'(occ4), 32'h0);
    chk("arst_empty4", 32'(empty4), 32'h1);
    chk("arst_q1", 32'(q1), 32'hA5);
    cyc(1'b1, 1'b0, 8'hEE, 1'b1);
    chk("arst_hold", 32'(occ4), 32'h0);
    #2;
    rst = 1'b1;

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 19) == 0),
          8'($urandom), 1'($urandom));
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
